// File: rtl/ecall_handler.sv
// Environment-call responder: stalls fetch, runs the I/O service selected by a7, writes results to a0.
// Define ECALL_CHAR_EN to implement the print-char service (code 11); otherwise code 11 is a no-op.
module ecall_handler #(
   parameter int SW_WIDTH = 16,
   parameter int A0_REG   = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ecall,
   input  logic [31:0]         a7_data,
   input  logic [31:0]         a0_data,
   input  logic [SW_WIDTH-1:0] switch,
   input  logic                confirm,
   output logic                stall,
   output logic                wb_en,
   output logic [4:0]          wb_sel,
   output logic [31:0]         wb_data,
   output logic [31:0]         display_data,
   output logic [7:0]          char_data,
   output logic                char_valid,
   output logic                halted
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_IN,
      WRITE,
      DONE,
      HALT
   } state_t;

   localparam logic [31:0] SVC_PRINT_INT = 32'd1;
   localparam logic [31:0] SVC_READ_INT  = 32'd5;
   localparam logic [31:0] SVC_EXIT      = 32'd10;
   localparam logic [31:0] SVC_PRINT_CHR = 32'd11;

   state_t      state, state_n;
   logic        wb_en_n, char_valid_n, halted_n;
   logic [31:0] wb_data_n, display_n;
   logic [7:0]  char_data_n;

   // NOTE: every comb output gets a default first so no path leaves it unassigned and infers a latch.
   always_comb begin
      state_n      = state;
      wb_en_n      = 1'b0;
      wb_data_n    = wb_data;
      display_n    = display_data;
      char_data_n  = char_data;
      char_valid_n = 1'b0;
      halted_n     = halted;
      case (state)
         IDLE: begin
            if (ecall) begin
               case (a7_data)
                  SVC_PRINT_INT: begin
                     display_n = a0_data;
                     state_n   = DONE;
                  end
                  SVC_READ_INT: state_n = WAIT_IN;
                  SVC_EXIT: begin
                     halted_n = 1'b1;
                     state_n  = HALT;
                  end
`ifdef ECALL_CHAR_EN
                  SVC_PRINT_CHR: begin
                     char_data_n  = a0_data[7:0];
                     char_valid_n = 1'b1;
                     state_n      = DONE;
                  end
`endif
                  default: state_n = DONE;
               endcase
            end
         end
         WAIT_IN: begin
            if (confirm) begin
               wb_data_n = 32'(switch);
               wb_en_n   = 1'b1;
               state_n   = WRITE;
            end
         end
         WRITE:   state_n = DONE;
         // DONE ignores ecall so the retiring instruction cannot trigger twice.
         DONE:    state_n = IDLE;
         HALT:    state_n = HALT;
         default: state_n = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         wb_en        <= 1'b0;
         wb_data      <= '0;
         display_data <= '0;
         char_data    <= '0;
         char_valid   <= 1'b0;
         halted       <= 1'b0;
      end else begin
         state        <= state_n;
         wb_en        <= wb_en_n;
         wb_data      <= wb_data_n;
         display_data <= display_n;
         char_data    <= char_data_n;
         char_valid   <= char_valid_n;
         halted       <= halted_n;
      end
   end

   assign stall  = ((state == IDLE) && ecall) || (state == WAIT_IN) ||
                   (state == WRITE) || (state == HALT);
   assign wb_sel = 5'(A0_REG);

endmodule

// File: tb/tb_ecall_handler.sv
// Scoreboard bench for ecall_handler: stimulus queues expected retire results, a monitor checks them.
module tb_ecall_handler;

   logic        clk = 1'b0;
   logic        rst;
   logic        ecall;
   logic [31:0] a7_data, a0_data;
   logic [15:0] switch;
   logic        confirm;
   logic        stall, wb_en, char_valid, halted;
   logic [4:0]  wb_sel;
   logic [31:0] wb_data, display_data;
   logic [7:0]  char_data;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       name;
      logic [31:0] display;
      logic [7:0]  chr;
      logic        cvalid;
      logic        wrote;
      logic [31:0] wdata;
      int          stall_cycles;
   } exp_t;

   exp_t sb[$];

   ecall_handler #(.SW_WIDTH(16), .A0_REG(10)) dut (
      .clk          (clk),
      .rst          (rst),
      .ecall        (ecall),
      .a7_data      (a7_data),
      .a0_data      (a0_data),
      .switch       (switch),
      .confirm      (confirm),
      .stall        (stall),
      .wb_en        (wb_en),
      .wb_sel       (wb_sel),
      .wb_data      (wb_data),
      .display_data (display_data),
      .char_data    (char_data),
      .char_valid   (char_valid),
      .halted       (halted)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: a retire is the cycle where the held ecall sees stall low (DONE).
   int          cyc = 0;
   logic        seen_wb = 1'b0;
   logic [31:0] seen_data = '0;
   exp_t        e;

   always @(negedge clk) begin
      if (rst) begin
         cyc     = 0;
         seen_wb = 1'b0;
      end else begin
         if (wb_en) begin
            seen_wb   = 1'b1;
            seen_data = wb_data;
            check("wb_sel", 32'(wb_sel), 32'd10);
         end
         if (char_valid && !(ecall && !stall))
            check("char_valid_outside_done", 32'(char_valid), 32'd0);
         if (ecall && stall) begin
            cyc++;
         end else if (ecall && !stall) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_retire: got retire expected none");
            end else begin
               e = sb.pop_front();
               check({e.name, "_display"}, display_data, e.display);
               check({e.name, "_char_data"}, 32'(char_data), 32'(e.chr));
               check({e.name, "_char_valid"}, 32'(char_valid), 32'(e.cvalid));
               check({e.name, "_wrote"}, 32'(seen_wb), 32'(e.wrote));
               if (e.wrote) check({e.name, "_wb_data"}, seen_data, e.wdata);
               check({e.name, "_stall_cycles"}, 32'(cyc), 32'(e.stall_cycles));
            end
            cyc     = 0;
            seen_wb = 1'b0;
         end
      end
   end

   task automatic wait_retire(input string name);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (ecall && !stall) return;
      end
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no retire expected retire within 60 cycles", name);
   endtask

   // Called just after a posedge; leaves ecall low one cycle after DONE unless the next issue follows.
   task automatic issue(input string name, input logic [31:0] a7, input logic [31:0] a0,
                        input exp_t ex);
      ecall   = 1'b1;
      a7_data = a7;
      a0_data = a0;
      sb.push_back(ex);
      wait_retire(name);
      @(posedge clk); #1;
      ecall = 1'b0;
   endtask

   logic [31:0] exp_disp = '0;
   logic [7:0]  exp_chr  = '0;
   exp_t        x;

   initial begin
      rst     = 1'b1;
      ecall   = 1'b0;
      a7_data = '0;
      a0_data = '0;
      switch  = '0;
      confirm = 1'b0;
      #3;
      check("reset_stall", 32'(stall), 32'd0);
      check("reset_wb_en", 32'(wb_en), 32'd0);
      check("reset_wb_data", wb_data, 32'd0);
      check("reset_display", display_data, 32'd0);
      check("reset_char", {23'd0, char_valid, char_data}, 32'd0);
      check("reset_halted", 32'(halted), 32'd0);
      check("reset_wb_sel", 32'(wb_sel), 32'd10);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Print int
      exp_disp = 32'h1234ABCD;
      x = '{"print", exp_disp, exp_chr, 1'b0, 1'b0, 32'd0, 1};
      issue("print", 32'd1, 32'h1234ABCD, x);

      // Stray confirm while idle must not matter
      confirm = 1'b1;
      @(posedge clk); #1;
      confirm = 1'b0;
      check("idle_confirm_stall", 32'(stall), 32'd0);

      // Read int: confirm in the detection cycle is ignored, the one 4 cycles later is taken
      switch  = 16'h8001;
      x = '{"read", exp_disp, exp_chr, 1'b0, 1'b1, 32'h00008001, 6};
      sb.push_back(x);
      ecall   = 1'b1;
      a7_data = 32'd5;
      a0_data = 32'h0;
      confirm = 1'b1;
      @(posedge clk); #1;
      confirm = 1'b0;
      switch  = 16'hFFFF;
      repeat (3) @(posedge clk);
      #1;
      switch  = 16'h8001;
      confirm = 1'b1;
      @(posedge clk); #1;
      confirm = 1'b0;
      switch  = 16'h5555;
      wait_retire("read");
      @(posedge clk); #1;
      ecall = 1'b0;

      // Print char
`ifdef ECALL_CHAR_EN
      exp_chr = 8'h41;
      x = '{"char", exp_disp, exp_chr, 1'b1, 1'b0, 32'd0, 1};
`else
      x = '{"char", exp_disp, exp_chr, 1'b0, 1'b0, 32'd0, 1};
`endif
      issue("char", 32'd11, 32'h41, x);

      // Unknown code, then print back-to-back with no idle gap
      x = '{"unknown", exp_disp, exp_chr, 1'b0, 1'b0, 32'd0, 1};
      ecall   = 1'b1;
      a7_data = 32'd99;
      a0_data = 32'hDEAD0000;
      sb.push_back(x);
      wait_retire("unknown");
      @(posedge clk); #1;
      exp_disp = 32'd7;
      x = '{"b2b_print", exp_disp, exp_chr, 1'b0, 1'b0, 32'd0, 1};
      issue("b2b_print", 32'd1, 32'd7, x);

      // Exit: stalled and halted until reset
      ecall   = 1'b1;
      a7_data = 32'd10;
      @(negedge clk);
      check("exit_detect_stall", 32'(stall), 32'd1);
      check("exit_detect_halted", 32'(halted), 32'd0);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         check("halt_stall", 32'(stall), 32'd1);
         check("halt_halted", 32'(halted), 32'd1);
      end
      @(posedge clk); #1;
      ecall = 1'b0;
      rst   = 1'b1;
      #1;
      check("halt_reset_halted", 32'(halted), 32'd0);
      check("halt_reset_stall", 32'(stall), 32'd0);
      check("halt_reset_display", display_data, 32'd0);
      @(posedge clk); #1;
      rst      = 1'b0;
      exp_disp = '0;
      exp_chr  = '0;

      // Service works again after reset
      exp_disp = 32'd7;
      x = '{"post_reset_print", exp_disp, exp_chr, 1'b0, 1'b0, 32'd0, 1};
      issue("post_reset_print", 32'd1, 32'd7, x);

      // Async reset while waiting for input: the read is abandoned
      ecall   = 1'b1;
      a7_data = 32'd5;
      switch  = 16'h1234;
      @(posedge clk);
      @(posedge clk); #3;
      check("wait_in_stall", 32'(stall), 32'd1);
      rst   = 1'b1;
      ecall = 1'b0;
      #1;
      check("async_rst_stall", 32'(stall), 32'd0);
      check("async_rst_wb_en", 32'(wb_en), 32'd0);
      check("async_rst_display", display_data, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("no_write_after_abort", 32'(wb_en), 32'd0);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
